// File: rtl/ref_out_pkg.sv
// Shared types and constants for the REF OUT divider: FSM state encoding,
// divisor limits and the PPS period-counter width.
package ref_out_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE     = 2'd0;
   localparam state_t RUN      = 2'd1;
   localparam state_t STOPPING = 2'd2;

   localparam int MIN_DIV     = 2;
   localparam int DEFAULT_DIV = 25;
   localparam int PPS_CNT_W   = 24;

endpackage

// File: rtl/ref_out_wave.sv
// Decodes (cnt, div_act) into registered rise/fall DDR data: div_act half-clock
// slots high per period, so odd divisors still give exactly 50% duty.
module ref_out_wave #(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 run,
   input  logic [DIV_WIDTH-1:0] cnt,
   input  logic [DIV_WIDTH-1:0] div_act,
   output logic                 ref_rise,
   output logic                 ref_fall
);

   logic [DIV_WIDTH-1:0] half;
   logic                 rise_d, rise_q;
   logic                 fall_d, fall_q;

   always_comb begin
      half   = div_act >> 1;
      fall_d = run && (cnt < half);
      // Odd divisors keep the extra half clock in the rising-edge slot at cnt == half.
      rise_d = fall_d || (run && div_act[0] && (cnt == half));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign ref_rise = rise_q;
   assign ref_fall = fall_q;

endmodule

// File: rtl/ref_out_gen.sv
// REF OUT generator: integer clock divider with glitch-free start/stop, boundary-only
// divisor changes and sync restart. Optional PPS pulse output when REF_OUT_PPS_EN is defined.
module ref_out_gen #(
   parameter int DIV_WIDTH   = 8,
   parameter int DEFAULT_DIV = ref_out_pkg::DEFAULT_DIV,
   parameter int PPS_PERIODS = 10000000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [DIV_WIDTH-1:0] div_in,
   input  logic                 div_load,
   input  logic                 sync_in,
   output logic                 ref_rise,
   output logic                 ref_fall,
   output logic                 active,
   output logic                 sync_err,
   output logic                 pps_out
);

   import ref_out_pkg::*;

   state_t               state_q, state_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] div_act_q, div_act_d;
   logic [DIV_WIDTH-1:0] div_pend_q, div_pend_d;
   logic                 load_pend_q, load_pend_d;
   logic                 sync_err_q, sync_err_d;

   logic                 running;
   logic                 wrap;
   logic                 restart;
   logic [DIV_WIDTH-1:0] last_cnt;
   logic [DIV_WIDTH-1:0] div_clamped;

   function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
      return (d < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : d;
   endfunction

   always_comb begin
      running     = (state_q != IDLE);
      last_cnt    = div_act_q - DIV_WIDTH'(1);
      wrap        = running && (cnt_q == last_cnt);
      restart     = running && (wrap || sync_in);
      div_clamped = clamp_div(div_in);

      state_d = state_q;
      case (state_q)
         IDLE:     if (enable) state_d = RUN;
         RUN:      if (!enable) state_d = STOPPING;
         STOPPING: begin
            if (enable)    state_d = RUN;
            else if (wrap) state_d = IDLE;
         end
         default:  state_d = IDLE;
      endcase

      if (!running || restart) cnt_d = '0;
      else                     cnt_d = cnt_q + DIV_WIDTH'(1);

      div_act_d   = div_act_q;
      div_pend_d  = div_pend_q;
      load_pend_d = load_pend_q;
      if (div_load) div_pend_d = div_clamped;
      // A load arriving on the restart cycle itself bypasses the pending register.
      if (!running) begin
         if (div_load) div_act_d = div_clamped;
      end else if (restart) begin
         if (div_load)         div_act_d = div_clamped;
         else if (load_pend_q) div_act_d = div_pend_q;
         load_pend_d = 1'b0;
      end else if (div_load) begin
         load_pend_d = 1'b1;
      end

      sync_err_d = running && sync_in && !wrap;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         div_act_q   <= DIV_WIDTH'(DEFAULT_DIV);
         div_pend_q  <= DIV_WIDTH'(DEFAULT_DIV);
         load_pend_q <= 1'b0;
         sync_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         div_act_q   <= div_act_d;
         div_pend_q  <= div_pend_d;
         load_pend_q <= load_pend_d;
         sync_err_q  <= sync_err_d;
      end
   end

   ref_out_wave #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_wave (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (running),
      .cnt      (cnt_q),
      .div_act  (div_act_q),
      .ref_rise (ref_rise),
      .ref_fall (ref_fall)
   );

   assign active   = running;
   assign sync_err = sync_err_q;

`ifdef REF_OUT_PPS_EN
   logic [PPS_CNT_W-1:0] pcnt_q, pcnt_d;
   logic                 pps_arm_q, pps_arm_d;
   logic                 pps_q, pps_d;

   // The pulse is armed at the period boundary and fires on cnt 0 so it lands with the first rise.
   always_comb begin
      pcnt_d    = pcnt_q;
      pps_arm_d = pps_arm_q;
      pps_d     = running && pps_arm_q && (cnt_q == '0);
      if (!running) begin
         pcnt_d    = '0;
         pps_arm_d = 1'b0;
      end else if (sync_in) begin
         pcnt_d    = '0;
         pps_arm_d = 1'b1;
      end else if (wrap) begin
         if (pcnt_q == PPS_CNT_W'(PPS_PERIODS - 1)) begin
            pcnt_d    = '0;
            pps_arm_d = 1'b1;
         end else begin
            pcnt_d = pcnt_q + PPS_CNT_W'(1);
         end
      end else if (pps_d) begin
         pps_arm_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q    <= '0;
         pps_arm_q <= 1'b0;
         pps_q     <= 1'b0;
      end else begin
         pcnt_q    <= pcnt_d;
         pps_arm_q <= pps_arm_d;
         pps_q     <= pps_d;
      end
   end

   assign pps_out = pps_q;
`else
   assign pps_out = 1'b0;
`endif

endmodule
